// File: rtl/ps2_cmd_scheduler_if.sv
// ---------------------------------------------------------------------------
// ps2_cmd_scheduler_if
//
// Bundles every non-clock signal of the PS/2 host command scheduler.
//   Requesters      : led_req/led_val, cmd_req/cmd_byte/cmd_has_arg/cmd_arg
//   Transmitter     : tx_start/tx_data (out), tx_done (in)
//   Receiver        : rx_valid/rx_data (in), rx_pass_valid/rx_pass_data (out)
//   Status          : busy, gnt (0 = LED, 1 = cmd), done, err
//
// Modport slave is the scheduler itself; modport master is the environment
// (requesters, transmitter and receiver) that surrounds it.
// ---------------------------------------------------------------------------
interface ps2_cmd_scheduler_if;
    logic       led_req;
    logic [2:0] led_val;
    logic       cmd_req;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_pass_valid;
    logic [7:0] rx_pass_data;
    logic       busy;
    logic       gnt;
    logic       done;
    logic       err;

    modport slave (
        input  led_req, led_val, cmd_req, cmd_byte, cmd_has_arg, cmd_arg,
        input  tx_done, rx_valid, rx_data,
        output tx_start, tx_data, rx_pass_valid, rx_pass_data,
        output busy, gnt, done, err
    );

    modport master (
        output led_req, led_val, cmd_req, cmd_byte, cmd_has_arg, cmd_arg,
        output tx_done, rx_valid, rx_data,
        input  tx_start, tx_data, rx_pass_valid, rx_pass_data,
        input  busy, gnt, done, err
    );
endinterface

// File: rtl/ps2_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// ps2_cmd_scheduler
//
// Host-side command scheduler for a PS/2 keyboard link. Arbitrates between an
// LED-update requester and a generic command requester (round-robin when both
// are pending, LED first after reset), sends the one- or two-byte command to
// the host transmitter, consumes the keyboard's 0xFA (ack) / 0xFE (resend)
// responses, retries up to MAX_RETRY times per byte and aborts on timeout.
// All other received bytes are forwarded to the scan-code path one cycle
// after they arrive.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low; clears all state and outputs
//   bus    : ps2_cmd_scheduler_if.slave (requests, tx/rx, status pulses)
//
// Parameters:
//   TIMEOUT_CYCLES : cycle limit in WAIT_TX / WAIT_RSP before aborting
//   MAX_RETRY      : resends allowed per byte before aborting
// ---------------------------------------------------------------------------
module ps2_cmd_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic               clk,
    input  logic               reset,
    ps2_cmd_scheduler_if.slave bus
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RTY_W = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_RSP,
        S_DONE,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;       // requester being served, 1 = cmd
    logic             last_cmd_q, last_cmd_d; // 1 = cmd was served last
    logic [7:0]       byte0_q, byte0_d;
    logic [7:0]       byte1_q, byte1_d;
    logic             two_q, two_d;           // sequence has a second byte
    logic             idx_q, idx_d;           // byte currently being sent
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             pass_valid_q, pass_valid_d;
    logic [7:0]       pass_data_q, pass_data_d;
    logic             busy_q, busy_d;
    logic             gnt_q, gnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             is_rsp;
    logic             pick_cmd;
    logic             tmo_hit;
    logic [TMO_W-1:0] tmo_inc;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave a value unassigned (no latch).
        state_d      = state_q;
        owner_d      = owner_q;
        last_cmd_d   = last_cmd_q;
        byte0_d      = byte0_q;
        byte1_d      = byte1_q;
        two_d        = two_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        pass_valid_d = 1'b0;
        pass_data_d  = pass_data_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        // Status outputs follow the state one cycle later, like every output.
        busy_d       = (state_q != S_IDLE);
        gnt_d        = owner_q;

        // 0xFA/0xFE are responses only while a response is awaited; any other
        // byte, or any byte in any other state, goes to the scan-code path.
        is_rsp   = (state_q == S_WAIT_RSP) && bus.rx_valid &&
                   ((bus.rx_data == RSP_ACK) || (bus.rx_data == RSP_RESEND));
        pick_cmd = bus.cmd_req && (!bus.led_req || !last_cmd_q);
        tmo_hit  = (tmo_q == TMO_LAST);
        tmo_inc  = tmo_hit ? tmo_q : tmo_q + 1'b1;

        if (bus.rx_valid && !is_rsp) begin
            pass_valid_d = 1'b1;
            pass_data_d  = bus.rx_data;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.led_req || bus.cmd_req) begin
                    owner_d = pick_cmd;
                    if (pick_cmd) begin
                        byte0_d = bus.cmd_byte;
                        byte1_d = bus.cmd_arg;
                        two_d   = bus.cmd_has_arg;
                    end else begin
                        byte0_d = CMD_SET_LEDS;
                        byte1_d = {5'b0, bus.led_val};
                        two_d   = 1'b1;
                    end
                    idx_d   = 1'b0;
                    retry_d = '0;
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                tx_start_d = 1'b1;
                tx_data_d  = idx_q ? byte1_q : byte0_q;
                tmo_d      = '0;
                state_d    = S_WAIT_TX;
            end

            // The awaited event is checked before the timeout so a
            // coincident tx_done still wins.
            S_WAIT_TX: begin
                if (bus.tx_done) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_RSP;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            // A forwarded scan code does not restart the timeout.
            S_WAIT_RSP: begin
                if (is_rsp && (bus.rx_data == RSP_ACK)) begin
                    if (!two_q || idx_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = 1'b1;
                        retry_d = '0;
                        state_d = S_SEND;
                    end
                end else if (is_rsp) begin
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_SEND;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            S_DONE: begin
                done_d     = 1'b1;
                last_cmd_d = owner_q;
                state_d    = S_IDLE;
            end

            S_ERR: begin
                err_d      = 1'b1;
                last_cmd_d = owner_q;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values computed before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_cmd_q   <= 1'b1;  // pretend cmd went last so LED wins first
            byte0_q      <= 8'h00;
            byte1_q      <= 8'h00;
            two_q        <= 1'b0;
            idx_q        <= 1'b0;
            retry_q      <= '0;
            tmo_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            pass_valid_q <= 1'b0;
            pass_data_q  <= 8'h00;
            busy_q       <= 1'b0;
            gnt_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_cmd_q   <= last_cmd_d;
            byte0_q      <= byte0_d;
            byte1_q      <= byte1_d;
            two_q        <= two_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            tmo_q        <= tmo_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            pass_valid_q <= pass_valid_d;
            pass_data_q  <= pass_data_d;
            busy_q       <= busy_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.tx_start      = tx_start_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.rx_pass_valid = pass_valid_q;
    assign bus.rx_pass_data  = pass_data_q;
    assign bus.busy          = busy_q;
    assign bus.gnt           = gnt_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ps2_cmd_scheduler
//
// Self-checking bench for ps2_cmd_scheduler. A transmitter/keyboard emulator
// answers each transmitted byte from a response plan; the plan, the expected
// byte stream, outcome, owner and forwarded bytes all come from a small
// reference model of the command protocol (round-robin pointer, byte lists,
// resend/abort rules).
// ---------------------------------------------------------------------------
module tb_ps2_cmd_scheduler;

    localparam int TIMEOUT   = 100;
    localparam int MAX_RETRY = 3;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_cmd_scheduler_if bus ();

    ps2_cmd_scheduler #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRY      (MAX_RETRY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    // Emulator plan and observations
    byte_q_t rsp_plan;
    int      inj_plan[$];
    byte_q_t obs_tx;
    byte_q_t obs_pass;
    int      rsp_lat[$];
    int      pass_lat[$];
    int      n_done, n_err, first_tx_cyc, txdone_cyc, end_cyc;
    logic    end_gnt, end_busy;
    bit      txn_timeout;

    // Reference model
    byte_q_t exp_tx;
    byte_q_t exp_pass;
    bit      exp_err;
    bit      last_cmd;   // 1 = cmd was served last

    function automatic bit same_q(input byte_q_t a, input byte_q_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit all_eq(input int q[$], input int v);
        foreach (q[i]) if (q[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int rand_scan();
        int v;
        do v = int'($urandom_range(0, 255)); while (v == 'hFA || v == 'hFE);
        return v;
    endfunction

    // k = resends answered for that byte before the ack; k > MAX_RETRY means
    // the keyboard keeps asking for resends; k < 0 means it never answers.
    function automatic void build_plan(input logic [7:0] b0, input logic [7:0] b1,
                                       input bit two, input int k0, input int k1,
                                       input int inj);
        exp_tx.delete(); exp_pass.delete(); rsp_plan.delete(); inj_plan.delete();
        exp_err = 1'b0;
        if (inj >= 0) begin
            inj_plan.push_back(inj);
            exp_pass.push_back(8'(inj));
        end
        for (int i = 0; i < (two ? 2 : 1); i++) begin
            logic [7:0] b = (i == 0) ? b0 : b1;
            int k = (i == 0) ? k0 : k1;
            if (k < 0) begin
                exp_tx.push_back(b);
                exp_err = 1'b1;
                break;
            end
            for (int s = 0; s < ((k > MAX_RETRY) ? MAX_RETRY + 1 : k + 1); s++) begin
                exp_tx.push_back(b);
                rsp_plan.push_back((s < k) ? 8'hFE : 8'hFA);
            end
            if (k > MAX_RETRY) begin
                exp_err = 1'b1;
                break;
            end
        end
    endfunction

    // Transmitter + keyboard emulator for one sequence; drops the served
    // request when done/err is seen.
    task automatic run_txn(input int budget);
        int cyc = 0;
        int phase = 0;
        int cnt = 0;
        logic [7:0] cur_rsp = 8'h00;
        bit have_rsp = 1'b0;
        int cur_inj = -1;
        int rsp_cyc = -1;
        int inj_cyc = -1;
        bit finished = 1'b0;
        obs_tx.delete(); obs_pass.delete(); rsp_lat.delete(); pass_lat.delete();
        n_done = 0; n_err = 0; first_tx_cyc = -1; txdone_cyc = -1; end_cyc = -1;
        txn_timeout = 1'b0;
        while (!finished && cyc < budget) begin
            @(negedge clk);
            cyc++;
            bus.tx_done  = 1'b0;
            bus.rx_valid = 1'b0;
            if (bus.rx_pass_valid) begin
                obs_pass.push_back(bus.rx_pass_data);
                pass_lat.push_back(cyc - inj_cyc);
            end
            if (bus.tx_start) begin
                obs_tx.push_back(bus.tx_data);
                if (first_tx_cyc < 0) first_tx_cyc = cyc;
                if (rsp_cyc >= 0) rsp_lat.push_back(cyc - rsp_cyc);
                rsp_cyc  = -1;
                have_rsp = (rsp_plan.size() != 0);
                if (have_rsp) cur_rsp = rsp_plan.pop_front();
                cur_inj  = (inj_plan.size() != 0) ? inj_plan.pop_front() : -1;
                phase    = 1;
                cnt      = int'($urandom_range(0, 2));
            end
            if (bus.done || bus.err) begin
                if (bus.done) n_done++;
                if (bus.err)  n_err++;
                end_gnt  = bus.gnt;
                end_busy = bus.busy;
                end_cyc  = cyc;
                if (rsp_cyc >= 0) rsp_lat.push_back(cyc - rsp_cyc);
                if (bus.gnt) bus.cmd_req = 1'b0;
                else         bus.led_req = 1'b0;
                finished = 1'b1;
            end else begin
                case (phase)
                    1: begin
                        if (cnt == 0) begin
                            bus.tx_done = 1'b1;
                            txdone_cyc  = cyc;
                            phase       = 2;
                            cnt         = int'($urandom_range(0, 3));
                        end else cnt--;
                    end
                    2: begin
                        if (cur_inj >= 0) begin
                            bus.rx_valid = 1'b1;
                            bus.rx_data  = 8'(cur_inj);
                            inj_cyc      = cyc;
                            cur_inj      = -1;
                        end else if (have_rsp) begin
                            if (cnt == 0) begin
                                bus.rx_valid = 1'b1;
                                bus.rx_data  = cur_rsp;
                                rsp_cyc      = cyc;
                                phase        = 0;
                            end else cnt--;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (!finished) begin
            txn_timeout = 1'b1;
            bus.led_req = 1'b0;
            bus.cmd_req = 1'b0;
        end
    endtask

    // Serve the next sequence the model predicts from the pending requests.
    task automatic serve(input string name, input int k0, input int k1, input int inj);
        bit pick_cmd = bus.cmd_req && (!bus.led_req || !last_cmd);
        int exp_done;
        if (pick_cmd) build_plan(bus.cmd_byte, bus.cmd_arg, bus.cmd_has_arg, k0, k1, inj);
        else          build_plan(8'hED, {5'b0, bus.led_val}, 1'b1, k0, k1, inj);
        exp_done = exp_err ? 0 : 1;
        run_txn(1000);
        last_cmd = pick_cmd;

        checks++;
        if (txn_timeout) $display("FAIL %s ended: no done/err within 1000 cycles", name);
        else passes++;
        checks++;
        if (n_done != exp_done || n_err != int'(exp_err))
            $display("FAIL %s outcome: done=%0d err=%0d, expected done=%0d err=%0d",
                     name, n_done, n_err, exp_done, exp_err);
        else passes++;
        checks++;
        if (end_gnt !== pick_cmd) $display("FAIL %s gnt: got %b expected %b", name, end_gnt, pick_cmd);
        else passes++;
        checks++;
        if (!same_q(obs_tx, exp_tx)) $display("FAIL %s tx bytes: got %p expected %p", name, obs_tx, exp_tx);
        else passes++;
        checks++;
        if (!same_q(obs_pass, exp_pass)) $display("FAIL %s forwarded: got %p expected %p", name, obs_pass, exp_pass);
        else passes++;
        checks++;
        if (!all_eq(rsp_lat, 2)) $display("FAIL %s response latency: got %p expected all 2", name, rsp_lat);
        else passes++;
        checks++;
        if (!all_eq(pass_lat, 1)) $display("FAIL %s forward latency: got %p expected all 1", name, pass_lat);
        else passes++;
        checks++;
        if (first_tx_cyc != 2) $display("FAIL %s first tx_start: got cycle %0d expected 2", name, first_tx_cyc);
        else passes++;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.led_req = 1'b0; bus.led_val = 3'b0; bus.cmd_req = 1'b0; bus.cmd_byte = 8'h00;
        bus.cmd_has_arg = 1'b0; bus.cmd_arg = 8'h00; bus.tx_done = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        last_cmd = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.tx_start, bus.tx_data, bus.rx_pass_valid, bus.rx_pass_data,
             bus.busy, bus.gnt, bus.done, bus.err} !== 22'h0)
            $display("FAIL reset_outputs: got %h expected 000000", {bus.tx_start, bus.tx_data,
                     bus.rx_pass_valid, bus.rx_pass_data, bus.busy, bus.gnt, bus.done, bus.err});
        else passes++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.tx_start, bus.busy, bus.done, bus.err} !== 4'h0)
            $display("FAIL post_reset_idle: got %b expected 0000",
                     {bus.tx_start, bus.busy, bus.done, bus.err});
        else passes++;
    endtask

    // 0xFA outside WAIT_RSP is just another received byte.
    task automatic test_idle_passthrough;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hFA;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checks++;
        if ({bus.rx_pass_valid, bus.rx_pass_data} !== {1'b1, 8'hFA})
            $display("FAIL idle_forward: got %b/%h expected 1/fa", bus.rx_pass_valid, bus.rx_pass_data);
        else passes++;
        @(negedge clk);
        checks++;
        if (bus.rx_pass_valid !== 1'b0)
            $display("FAIL idle_forward_strobe: got %b expected 0", bus.rx_pass_valid);
        else passes++;
    endtask

    task automatic test_arbitration;
        bus.led_val = 3'(($urandom_range(0, 7)));
        bus.cmd_byte = 8'($urandom_range(0, 255));
        bus.cmd_arg = 8'($urandom_range(0, 255));
        bus.cmd_has_arg = 1'b1;
        bus.led_req = 1'b1;
        bus.cmd_req = 1'b1;
        serve("arb_first", 0, 0, 'h1C);
        checks++;
        if (end_gnt !== 1'b0) $display("FAIL arb_led_first: got gnt %b expected 0", end_gnt);
        else passes++;
        serve("arb_second", 0, 0, -1);
    endtask

    task automatic test_led_update;
        @(negedge clk);
        bus.led_val = 3'b101;
        bus.led_req = 1'b1;
        serve("led", 0, 0, -1);
        checks++;
        if (obs_tx.size() != 2 || obs_tx[0] !== 8'hED || obs_tx[1] !== 8'h05)
            $display("FAIL led_bytes: got %p expected ed 05", obs_tx);
        else passes++;
        checks++;
        if (obs_pass.size() != 0) $display("FAIL led_no_forward: got %0d forwarded expected 0", obs_pass.size());
        else passes++;
    endtask

    task automatic test_resend;
        @(negedge clk);
        bus.cmd_byte = 8'hF4;
        bus.cmd_has_arg = 1'b0;
        bus.cmd_req = 1'b1;
        serve("resend", 1, 0, -1);
        checks++;
        if (obs_tx.size() != 2 || obs_tx[0] !== 8'hF4 || obs_tx[1] !== 8'hF4)
            $display("FAIL resend_bytes: got %p expected f4 f4", obs_tx);
        else passes++;
    endtask

    task automatic test_retry_exhaust;
        @(negedge clk);
        bus.cmd_byte = 8'($urandom_range(0, 255));
        bus.cmd_has_arg = 1'($urandom_range(0, 1));
        bus.cmd_req = 1'b1;
        serve("retry", MAX_RETRY + 1, 0, -1);
        checks++;
        if (obs_tx.size() != 4 || end_busy !== 1'b1)
            $display("FAIL retry_pulses: got %0d tx, busy %b expected 4 tx, busy 1", obs_tx.size(), end_busy);
        else passes++;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL retry_busy_fall: got %b expected 0", bus.busy);
        else passes++;
    endtask

    // A scan code arriving mid-wait must not restart the timeout.
    task automatic test_timeout;
        @(negedge clk);
        bus.cmd_byte = 8'($urandom_range(0, 255));
        bus.cmd_has_arg = 1'b0;
        bus.cmd_req = 1'b1;
        serve("timeout", -1, 0, rand_scan());
        checks++;
        if (end_cyc - txdone_cyc != TIMEOUT + 2)
            $display("FAIL timeout_cycles: got %0d expected %0d", end_cyc - txdone_cyc, TIMEOUT + 2);
        else passes++;
    endtask

    task automatic test_reset_mid;
        bit found = 1'b0;
        bit saw = 1'b0;
        @(negedge clk);
        bus.cmd_byte = 8'($urandom_range(0, 255));
        bus.cmd_has_arg = 1'b0;
        bus.cmd_req = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.tx_start) found = 1'b1;
        end
        checks++;
        if (!found) $display("FAIL reset_mid_start: got no tx_start expected one within 10 cycles");
        else passes++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.tx_start, bus.tx_data, bus.rx_pass_valid, bus.rx_pass_data,
             bus.busy, bus.gnt, bus.done, bus.err} !== 22'h0)
            $display("FAIL reset_mid_outputs: got %h expected 000000", {bus.tx_start, bus.tx_data,
                     bus.rx_pass_valid, bus.rx_pass_data, bus.busy, bus.gnt, bus.done, bus.err});
        else passes++;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.err) saw = 1'b1;
        end
        checks++;
        if (saw) $display("FAIL reset_mid_pulse: got done/err expected none");
        else passes++;
        bus.cmd_req = 1'b0;
        reset = 1'b1;
        last_cmd = 1'b1;
        @(negedge clk);
        bus.led_val = 3'($urandom_range(0, 7));
        bus.led_req = 1'b1;
        serve("after_reset", 0, 0, -1);
    endtask

    task automatic test_random;
        for (int it = 0; it < 25; it++) begin
            int pattern = int'($urandom_range(1, 3));
            @(negedge clk);
            bus.led_val = 3'($urandom_range(0, 7));
            bus.cmd_byte = 8'($urandom_range(0, 255));
            bus.cmd_arg = 8'($urandom_range(0, 255));
            bus.cmd_has_arg = 1'($urandom_range(0, 1));
            bus.led_req = pattern[0];
            bus.cmd_req = pattern[1];
            for (int j = 0; j < ((pattern == 3) ? 2 : 1); j++) begin
                int k0 = ($urandom_range(0, 7) == 0) ? MAX_RETRY + 1 : int'($urandom_range(0, 2));
                int k1 = ($urandom_range(0, 7) == 0) ? MAX_RETRY + 1 : int'($urandom_range(0, 2));
                int inj = ($urandom_range(0, 2) == 0) ? rand_scan() : -1;
                serve("random", k0, k1, inj);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_idle_passthrough();
        test_led_update();
        test_resend();
        test_retry_exhaust();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2 ms expected finish earlier");
        $fatal(1);
    end

endmodule

// File: doc/ps2_cmd_scheduler.md
# ps2_cmd_scheduler

Host-side command scheduler for the PS/2 keyboard link. It arbitrates between two requesters: an LED-update source and a generic command source. It sequences each command as one or two bytes into the PS/2 host transmitter (the unit driven by `w_enable`), consumes the keyboard's 0xFA/0xFE responses, retries on resend, and aborts on timeout. All other received bytes pass through unchanged to the scan-code path.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 2000000: max clk cycles allowed in any wait state (20 ms at 100 MHz).
- `MAX_RETRY`, default 3: resends allowed per byte before abort.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low; low clears all state and outputs.
- `led_req` in 1: LED update request; held with `led_val` stable until `done`/`err` with `gnt`=0.
- `led_val` in 3: {caps, num, scroll}.
- `cmd_req` in 1: generic command request; held with its data stable until `done`/`err` with `gnt`=1.
- `cmd_byte` in 8: command opcode.
- `cmd_has_arg` in 1: 1 = send `cmd_arg` after `cmd_byte` is acknowledged.
- `cmd_arg` in 8: argument byte.
- `tx_start` out 1: one-cycle pulse to the transmitter (`w_enable`).
- `tx_data` out 8: byte to transmit; valid from the `tx_start` cycle, held until the next `tx_start`.
- `tx_done` in 1: one-cycle pulse from the transmitter when the device ack bit has been sampled.
- `rx_valid` in 1: one-cycle strobe, received byte available.
- `rx_data` in 8: received byte.
- `rx_pass_valid` out 1: forwarded strobe.
- `rx_pass_data` out 8: forwarded byte.
- `busy` out 1: high in every state except IDLE.
- `gnt` out 1: current owner, 0 = LED, 1 = cmd; valid while `busy` and during `done`/`err`.
- `done` out 1: one-cycle pulse, sequence completed.
- `err` out 1: one-cycle pulse, sequence aborted.

## Operation
- States: IDLE, SEND, WAIT_TX, WAIT_RSP, DONE, ERR. All outputs are registered.
- **IDLE, arbitration:**
  - A single pending request wins.
  - If both are pending, round-robin: the requester not served last wins. After reset, LED has priority.
  - On a grant, latch the requester's bytes, set `gnt`, clear the byte index and retry counter, and go to SEND.
- **Byte list:**
  - LED: 0xED, then {5'b0, led_val}.
  - cmd: `cmd_byte`, then `cmd_arg` only if `cmd_has_arg`=1.
- **SEND:** drive `tx_start`=1 and `tx_data`=current byte for one cycle, then go to WAIT_TX with the timeout counter cleared.
- **WAIT_TX:** on `tx_done`, go to WAIT_RSP with the timeout counter cleared.
- **WAIT_RSP:**
  - `rx_valid` with 0xFA: if the last byte was sent, go to DONE. Otherwise advance the byte index, clear the retry counter, and go to SEND.
  - `rx_valid` with 0xFE: if retry count is below MAX_RETRY, increment it and go to SEND with the same byte. Otherwise go to ERR.
  - `rx_valid` with any other byte: forward it and stay in WAIT_RSP. The timeout counter is not cleared.
- **Timeout:** in WAIT_TX or WAIT_RSP, when the counter reaches TIMEOUT_CYCLES-1 without the awaited event, go to ERR.
- **DONE / ERR:** pulse `done` / `err` for one cycle, record `gnt` as last served, and return to IDLE.
- **Forwarding:**
  - In every state other than WAIT_RSP, each `rx_valid` is forwarded.
  - 0xFA and 0xFE are consumed only in WAIT_RSP.
  - Forward latency is 1 cycle.
- The timeout counter saturates and is wide enough for TIMEOUT_CYCLES.
- The retry counter is sized to hold MAX_RETRY.

## Timing
- **Reset values:** `tx_start`=0, `tx_data`=0x00, `rx_pass_valid`=0, `rx_pass_data`=0x00, `busy`=0, `gnt`=0, `done`=0, `err`=0, state IDLE, round-robin pointer favouring LED. Asserting `reset` mid-sequence aborts without an `err` pulse.
- **Request to first byte:** a request sampled high at edge k in IDLE gives SEND at k+1 and `tx_start` high in cycle k+1..k+2.
- **Ack to next byte:** 0xFA sampled at edge m gives the next `tx_start` one cycle later, or `done` high one cycle later for the last byte.
- **Back-to-back requests:** `busy` falls the cycle after `done`/`err`. The earliest next grant is 2 cycles after `done`.
- **Simultaneous events:** `rx_valid` and timeout in the same cycle resolves to rx (the response wins). `tx_done` and timeout in the same cycle resolves to `tx_done`.
- An `rx_valid` arriving while in WAIT_TX is forwarded, not treated as a response.
- Requests dropped while not granted are ignored. Dropping a request while it is granted does not abort the sequence.

## Test plan
- **LED update:** `led_req`, `led_val`=3'b101; bench returns `tx_done` then 0xFA twice → `tx_data` 0xED then 0x05, one `done` with `gnt`=0, no `rx_pass_valid`.
- **Resend:** `cmd_req`, `cmd_byte`=0xF4, `cmd_has_arg`=0; reply 0xFE, then 0xFA → `tx_start` pulses twice with 0xF4, `done` with `gnt`=1.
- **Retry exhaustion:** reply 0xFE four times with MAX_RETRY=3 → 4 `tx_start` pulses, `err` pulse, `busy` low next cycle.
- **Timeout:** TIMEOUT_CYCLES=100, `tx_done` given, no response → `err` exactly 100 cycles after entering WAIT_RSP, plus one state-transition cycle.
- **Arbitration and passthrough:** `led_req` and `cmd_req` both high from reset → LED served first, cmd second. Scan code 0x1C injected during WAIT_RSP → forwarded with 1-cycle latency and the sequence unaffected.
- **Reset mid-sequence:** `reset` low during WAIT_TX → all outputs at reset values immediately, no `done`/`err`; after release, a new request is served normally.
